// File: rtl/cpu_ctrl_pkg.sv
// Shared constants, state type and control-word layout for the multicycle CPU controller.
package cpu_ctrl_pkg;

   localparam int unsigned OP_ADD  = 0;
   localparam int unsigned OP_ADDI = 1;
   localparam int unsigned OP_SUB  = 2;
   localparam int unsigned OP_AND  = 3;
   localparam int unsigned OP_LW   = 4;
   localparam int unsigned OP_SW   = 5;
   localparam int unsigned OP_BNE  = 6;
   localparam int unsigned OP_J    = 7;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;

   localparam logic [1:0] SRCB_REGB = 2'b00;
   localparam logic [1:0] SRCB_ONE  = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      ST_RST, ST_FETCH, ST_DECODE, ST_EXR, ST_EXI, ST_AWB,
      ST_MADR, ST_MRD, ST_MWB, ST_MWR, ST_BR, ST_JMP
   } ctrl_state_t;

   // fetch qualifies ir_write/pc_write with mem_ready outside the register
   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       i_or_d;
      logic       fetch;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_control;
      logic       reg_write;
      logic       mem_to_reg;
   } ctrl_out_t;

   function automatic ctrl_out_t decode_outputs(input ctrl_state_t st, input logic [2:0] r_alu);
      ctrl_out_t o;
      o = '0;
      case (st)
         ST_FETCH: begin
            o.mem_req     = 1'b1;
            o.fetch       = 1'b1;
            o.pc_src      = PCSRC_ALU;
            o.alu_src_b   = SRCB_ONE;
            o.alu_control = ALU_ADD;
         end
         ST_DECODE, ST_EXI, ST_MADR: begin
            o.alu_src_a   = (st != ST_DECODE);
            o.alu_src_b   = SRCB_IMM;
            o.alu_control = ALU_ADD;
         end
         ST_EXR: begin
            o.alu_src_a   = 1'b1;
            o.alu_src_b   = SRCB_REGB;
            o.alu_control = r_alu;
         end
         ST_AWB: o.reg_write = 1'b1;
         ST_MRD: begin
            o.mem_req = 1'b1;
            o.i_or_d  = 1'b1;
         end
         ST_MWB: begin
            o.reg_write  = 1'b1;
            o.mem_to_reg = 1'b1;
         end
         ST_MWR: begin
            o.mem_req = 1'b1;
            o.mem_we  = 1'b1;
            o.i_or_d  = 1'b1;
         end
         ST_BR: begin
            o.alu_src_a     = 1'b1;
            o.alu_src_b     = SRCB_REGB;
            o.alu_control   = ALU_SUB;
            o.pc_src        = PCSRC_ALUOUT;
            o.pc_write_cond = 1'b1;
         end
         ST_JMP: begin
            o.pc_src   = PCSRC_JUMP;
            o.pc_write = 1'b1;
         end
         default: o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Per-access memory wait counter; flags the last allowed not-ready cycle.
module ctrl_wait_timer
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic tick,
   output logic expired
);

   localparam int unsigned CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= cnt + CW'(1);
      end
   end

   // a ready cycle never ticks, so ready always beats the timeout
   assign expired = (TIMEOUT != 0) && tick && (cnt == CW'(LAST));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back with
// a timed memory handshake, sticky error flags and a retired-instruction counter.
module multicycle_control
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned OPW     = 4,
   parameter int unsigned CNTW    = 16,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OPW-1:0]  opcode,
   input  logic            alu_zero,
   input  logic            mem_ready,
   input  logic            clr_err,
   output logic            mem_req,
   output logic            mem_we,
   output logic            i_or_d,
   output logic            ir_write,
   output logic            pc_en,
   output logic [1:0]      pc_src,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [2:0]      alu_control,
   output logic            reg_write,
   output logic            mem_to_reg,
   output logic            illegal_op,
   output logic            bus_err,
   output logic [CNTW-1:0] instr_retired
);

   ctrl_state_t    state_q, state_d;
   logic [OPW-1:0] op_q, op_d;
   ctrl_out_t      out_q, out_d;
   logic [2:0]     r_alu_d;
   logic           illegal_set;
   logic           retire;
   logic           timeout;
   logic           timer_clr;
   logic           timer_tick;

   // registered mem_req is high exactly in the memory states
   assign timer_tick = out_q.mem_req & ~mem_ready;
   assign timer_clr  = (state_d != state_q) | timeout;

   ctrl_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (timer_clr),
      .tick    (timer_tick),
      .expired (timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RST;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      illegal_set = 1'b0;
      retire      = 1'b0;
      unique case (state_q)
         ST_RST:    state_d = ST_FETCH;
         ST_FETCH: begin
            if (mem_ready) state_d = ST_DECODE;
            else           state_d = ST_FETCH;
         end
         ST_DECODE: begin
            case (opcode)
               OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_AND): state_d = ST_EXR;
               OPW'(OP_ADDI):                            state_d = ST_EXI;
               OPW'(OP_LW), OPW'(OP_SW):                 state_d = ST_MADR;
               OPW'(OP_BNE):                             state_d = ST_BR;
               OPW'(OP_J):                               state_d = ST_JMP;
               default: begin
                  state_d     = ST_FETCH;
                  illegal_set = 1'b1;
               end
            endcase
         end
         ST_EXR, ST_EXI: state_d = ST_AWB;
         ST_MADR: state_d = (op_q == OPW'(OP_SW)) ? ST_MWR : ST_MRD;
         ST_MRD: begin
            if (mem_ready)    state_d = ST_MWB;
            else if (timeout) state_d = ST_FETCH;
         end
         ST_MWR: begin
            if (mem_ready) begin
               state_d = ST_FETCH;
               retire  = 1'b1;
            end else if (timeout) begin
               state_d = ST_FETCH;
            end
         end
         ST_AWB, ST_MWB, ST_BR, ST_JMP: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // opcode is captured during DECODE; later states see only op_q
   assign op_d = (state_q == ST_DECODE) ? opcode : op_q;

   always_comb begin
      r_alu_d = ALU_ADD;
      if (op_d == OPW'(OP_SUB))      r_alu_d = ALU_SUB;
      else if (op_d == OPW'(OP_AND)) r_alu_d = ALU_AND;
   end

   assign out_d = decode_outputs(state_d, r_alu_d);

   // control word, sticky flags and retire counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q          <= '0;
         out_q         <= '0;
         illegal_op    <= 1'b0;
         bus_err       <= 1'b0;
         instr_retired <= '0;
      end else begin
         op_q       <= op_d;
         out_q      <= out_d;
         illegal_op <= illegal_set | (illegal_op & ~clr_err);
         bus_err    <= timeout | (bus_err & ~clr_err);
         if (retire) instr_retired <= instr_retired + CNTW'(1);
      end
   end

   assign mem_req     = out_q.mem_req;
   assign mem_we      = out_q.mem_we;
   assign i_or_d      = out_q.i_or_d;
   assign pc_src      = out_q.pc_src;
   assign alu_src_a   = out_q.alu_src_a;
   assign alu_src_b   = out_q.alu_src_b;
   assign alu_control = out_q.alu_control;
   assign reg_write   = out_q.reg_write;
   assign mem_to_reg  = out_q.mem_to_reg;
   assign ir_write    = out_q.fetch & mem_ready;
   assign pc_en       = out_q.pc_write | (out_q.fetch & mem_ready) |
                        (out_q.pc_write_cond & ~alu_zero);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed cycle table, mid-access reset, counter wrap,
// and randomized traffic checked against an instruction-step reference model.
module tb_multicycle_control;

   localparam int unsigned TO = 4;
   localparam int unsigned CW = 4;

   localparam int K_RST = 0, K_FETCH = 1, K_DEC = 2, K_EXR = 3, K_EXI = 4, K_AWB = 5;
   localparam int K_ADDR = 6, K_RD = 7, K_MWB = 8, K_WR = 9, K_BR = 10, K_JMP = 11;

   typedef struct {
      int op, az, rdy, clr;
      int mreq, mwe, irw, pcen, psrc, srcb, alu, rw, m2r, ill, berr, ret;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    opcode;
   logic          alu_zero, mem_ready, clr_err;
   logic          mem_req, mem_we, i_or_d, ir_write, pc_en;
   logic [1:0]    pc_src, alu_src_b;
   logic          alu_src_a, reg_write, mem_to_reg, illegal_op, bus_err;
   logic [2:0]    alu_control;
   logic [CW-1:0] instr_retired;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // reference model: remaining steps of the current instruction
   int steps[$];
   int m_op, m_wait, m_ret;
   bit m_ill, m_berr;

   vec_t tbl[34];

   multicycle_control #(.OPW(4), .CNTW(CW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero),
      .mem_ready(mem_ready), .clr_err(clr_err), .mem_req(mem_req), .mem_we(mem_we),
      .i_or_d(i_or_d), .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal_op(illegal_op),
      .bus_err(bus_err), .instr_retired(instr_retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      steps.delete();
      steps.push_back(K_RST);
      m_op = 0; m_wait = 0; m_ret = 0; m_ill = 1'b0; m_berr = 1'b0;
   endtask

   task automatic check_model();
      int s, mreq, mwe, iord, irw, pcen, psrc, srca, srcb, alu, rw, m2r;
      s = steps[0];
      mreq = 0; mwe = 0; iord = 0; irw = 0; pcen = 0; psrc = 0;
      srca = 0; srcb = 0; alu = 0; rw = 0; m2r = 0;
      case (s)
         K_FETCH: begin mreq = 1; irw = int'(mem_ready); pcen = int'(mem_ready); srcb = 1; alu = 2; end
         K_DEC:   begin srcb = 2; alu = 2; end
         K_EXR:   begin srca = 1; alu = (m_op == 2) ? 6 : (m_op == 3) ? 0 : 2; end
         K_EXI, K_ADDR: begin srca = 1; srcb = 2; alu = 2; end
         K_AWB:   rw = 1;
         K_RD:    begin mreq = 1; iord = 1; end
         K_MWB:   begin rw = 1; m2r = 1; end
         K_WR:    begin mreq = 1; mwe = 1; iord = 1; end
         K_BR:    begin srca = 1; alu = 6; psrc = 1; pcen = int'(!alu_zero); end
         K_JMP:   begin psrc = 2; pcen = 1; end
         default: ;
      endcase
      chk("mem_req", int'(mem_req), mreq);
      chk("mem_we", int'(mem_we), mwe);
      chk("i_or_d", int'(i_or_d), iord);
      chk("ir_write", int'(ir_write), irw);
      chk("pc_en", int'(pc_en), pcen);
      chk("pc_src", int'(pc_src), psrc);
      chk("alu_src_a", int'(alu_src_a), srca);
      chk("alu_src_b", int'(alu_src_b), srcb);
      chk("alu_control", int'(alu_control), alu);
      chk("reg_write", int'(reg_write), rw);
      chk("mem_to_reg", int'(mem_to_reg), m2r);
      chk("illegal_op", int'(illegal_op), int'(m_ill));
      chk("bus_err", int'(bus_err), int'(m_berr));
      chk("instr_retired", int'(instr_retired), m_ret);
   endtask

   // advance the model by one clock with the inputs of the cycle just checked
   task automatic model_step(input int op, input int rdy, input int clr);
      int s;
      bit pop, s_ill, s_berr;
      s = steps[0];
      pop = 1'b0; s_ill = 1'b0; s_berr = 1'b0;
      if (s == K_FETCH || s == K_RD || s == K_WR) begin
         if (rdy != 0) begin
            pop = 1'b1;
            m_wait = 0;
         end else begin
            m_wait++;
            if (TO != 0 && m_wait == int'(TO)) begin
               s_berr = 1'b1;
               m_wait = 0;
               steps.delete();
            end
         end
      end else begin
         pop = 1'b1;
      end
      if (pop) begin
         void'(steps.pop_front());
         if (s == K_DEC) begin
            m_op = op;
            case (op)
               0, 2, 3: begin steps.push_back(K_EXR); steps.push_back(K_AWB); end
               1:       begin steps.push_back(K_EXI); steps.push_back(K_AWB); end
               4:       begin steps.push_back(K_ADDR); steps.push_back(K_RD); steps.push_back(K_MWB); end
               5:       begin steps.push_back(K_ADDR); steps.push_back(K_WR); end
               6:       steps.push_back(K_BR);
               7:       steps.push_back(K_JMP);
               default: s_ill = 1'b1;
            endcase
         end else if (s != K_RST && steps.size() == 0) begin
            m_ret = (m_ret + 1) % (1 << CW);
         end
      end
      if (clr != 0) begin m_ill = 1'b0; m_berr = 1'b0; end
      if (s_ill) m_ill = 1'b1;
      if (s_berr) m_berr = 1'b1;
      if (steps.size() == 0) begin
         steps.push_back(K_FETCH);
         steps.push_back(K_DEC);
      end
   endtask

   task automatic run_cycle(input vec_t v, input bit use_tbl);
      opcode    = 4'(v.op);
      alu_zero  = 1'(v.az);
      mem_ready = 1'(v.rdy);
      clr_err   = 1'(v.clr);
      #1;
      check_model();
      if (use_tbl) begin
         chk("tbl_mem_req", int'(mem_req), v.mreq);
         chk("tbl_mem_we", int'(mem_we), v.mwe);
         chk("tbl_ir_write", int'(ir_write), v.irw);
         chk("tbl_pc_en", int'(pc_en), v.pcen);
         chk("tbl_pc_src", int'(pc_src), v.psrc);
         chk("tbl_alu_src_b", int'(alu_src_b), v.srcb);
         chk("tbl_alu_control", int'(alu_control), v.alu);
         chk("tbl_reg_write", int'(reg_write), v.rw);
         chk("tbl_mem_to_reg", int'(mem_to_reg), v.m2r);
         chk("tbl_illegal_op", int'(illegal_op), v.ill);
         chk("tbl_bus_err", int'(bus_err), v.berr);
         chk("tbl_instr_retired", int'(instr_retired), v.ret);
      end
      model_step(v.op, v.rdy, v.clr);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;
      //          op az rdy clr  mreq mwe irw pcen psrc srcb alu rw m2r ill berr ret
      tbl[0]  = '{0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};  // RST
      tbl[1]  = '{0, 0, 1, 0,   1, 0, 1, 1, 0, 1, 2, 0, 0, 0, 0, 0};  // add
      tbl[2]  = '{0, 0, 0, 0,   0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0};
      tbl[3]  = '{0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0};
      tbl[4]  = '{0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
      tbl[5]  = '{4, 0, 1, 0,   1, 0, 1, 1, 0, 1, 2, 0, 0, 0, 0, 1};  // lw, 3 waits
      tbl[6]  = '{4, 0, 0, 0,   0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 1};
      tbl[7]  = '{4, 0, 0, 0,   0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 1};
      tbl[8]  = '{4, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      tbl[9]  = '{4, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      tbl[10] = '{4, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      tbl[11] = '{4, 0, 1, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      tbl[12] = '{4, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1};
      tbl[13] = '{6, 0, 1, 0,   1, 0, 1, 1, 0, 1, 2, 0, 0, 0, 0, 2};  // bne taken
      tbl[14] = '{6, 0, 0, 0,   0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 2};
      tbl[15] = '{6, 0, 0, 0,   0, 0, 0, 1, 1, 0, 6, 0, 0, 0, 0, 2};
      tbl[16] = '{6, 1, 1, 0,   1, 0, 1, 1, 0, 1, 2, 0, 0, 0, 0, 3};  // bne not taken
      tbl[17] = '{6, 1, 0, 0,   0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 3};
      tbl[18] = '{6, 1, 0, 0,   0, 0, 0, 0, 1, 0, 6, 0, 0, 0, 0, 3};
      tbl[19] = '{10, 0, 1, 0,  1, 0, 1, 1, 0, 1, 2, 0, 0, 0, 0, 4};  // illegal opcode
      tbl[20] = '{10, 0, 0, 0,  0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 4};
      tbl[21] = '{7, 0, 1, 1,   1, 0, 1, 1, 0, 1, 2, 0, 0, 1, 0, 4};  // clr_err, then j
      tbl[22] = '{7, 0, 0, 0,   0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 4};
      tbl[23] = '{7, 0, 0, 0,   0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 4};
      tbl[24] = '{5, 0, 1, 0,   1, 0, 1, 1, 0, 1, 2, 0, 0, 0, 0, 5};  // sw timeout
      tbl[25] = '{5, 0, 0, 0,   0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 5};
      tbl[26] = '{5, 0, 0, 0,   0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 5};
      tbl[27] = '{5, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5};
      tbl[28] = '{5, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5};
      tbl[29] = '{5, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5};
      tbl[30] = '{5, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5};
      tbl[31] = '{5, 0, 1, 0,   1, 0, 1, 1, 0, 1, 2, 0, 0, 0, 1, 5};
      tbl[32] = '{5, 0, 0, 0,   0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 1, 5};
      tbl[33] = '{5, 0, 0, 0,   0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 1, 5};

      rst_n = 1'b0; opcode = '0; alu_zero = 1'b0; mem_ready = 1'b1; clr_err = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      chk("rst_mem_req", int'(mem_req), 0);
      chk("rst_ir_write", int'(ir_write), 0);
      chk("rst_pc_en", int'(pc_en), 0);
      chk("rst_alu_src_b", int'(alu_src_b), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 34; i++) run_cycle(tbl[i], 1'b1);

      // MWR in progress, then reset mid-cycle: outputs must drop at once
      v = '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      opcode = 4'd5; mem_ready = 1'b0;
      #1;
      check_model();
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_mem_req", int'(mem_req), 0);
      chk("async_mem_we", int'(mem_we), 0);
      chk("async_i_or_d", int'(i_or_d), 0);
      chk("async_bus_err", int'(bus_err), 0);
      chk("async_instr_retired", int'(instr_retired), 5 - 5);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // sixteen jumps wrap the 4-bit retire counter back to zero
      v = '{7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 1 + 16 * 3; i++) run_cycle(v, 1'b0);
      #0;
      chk("wrap_instr_retired", int'(instr_retired), 0);

      for (int i = 0; i < 3000; i++) begin
         v.op  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
         v.az  = int'($urandom_range(0, 1));
         v.rdy = ($urandom_range(0, 9) < 6) ? 1 : 0;
         v.clr = ($urandom_range(0, 15) == 0) ? 1 : 0;
         run_cycle(v, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
